rs_age_bank: RTL and testbench

Parametrised reservation-station bank that replaces the flat RS array plus external crossbars with self-contained allocation, tag wakeup and oldest-first multi-lane issue. It sits between dispatch and the functional-unit issue ports. Per cycle it accepts up to DISP_W instructions, tracks operand readiness against writeback and issue tag broadcasts, and issues up to ISS_W ready entries in program-age order with an FU accept handshake.

---
 rtl/rs_age_bank.sv | 234 +++++++++++++++++++++++
 tb/tb_rs_age_bank.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_age_bank.sv
// rtl/rs_age_bank.sv - reservation-station bank with tag wakeup and oldest-first multi-lane issue
//
// Purpose: holds up to RS_DEPTH instructions between dispatch and the FU issue
// ports. Entries are allocated lowest-free-index first, woken by tag broadcast,
// and issued oldest-first (wrap-aware ROB age) on up to ISS_W lanes.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   flush               drop all entries at the edge, suppress issue this cycle
//   disp_*              DISP_W dispatch lanes (valid lanes contiguous from lane 0)
//   wb_valid, wb_tag    WB_W writeback tag broadcast lanes
//   iss_ready           per-lane FU accept
//   iss_valid, iss_dest_tag, iss_payload   combinational issue lanes
//   free_cnt            registered count of free entries
//   overflow            sticky, set when a dispatch lane found no free entry
//
// Optional feature: define RS_SPEC_WAKEUP_EN to also use accepted issue-lane
// destination tags as wakeup (and dispatch bypass) sources at the same edge.

module rs_age_bank #(
  parameter int RS_DEPTH = 8,
  parameter int DISP_W   = 2,
  parameter int ISS_W    = 2,
  parameter int WB_W     = 2,
  parameter int TAG_W    = 6,
  parameter int AGE_W    = 6,
  parameter int PAY_W    = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [DISP_W-1:0]             disp_valid,
  input  logic [DISP_W*TAG_W-1:0]       disp_src1_tag,
  input  logic [DISP_W*TAG_W-1:0]       disp_src2_tag,
  input  logic [DISP_W*TAG_W-1:0]       disp_dest_tag,
  input  logic [DISP_W-1:0]             disp_src1_rdy,
  input  logic [DISP_W-1:0]             disp_src2_rdy,
  input  logic [DISP_W*AGE_W-1:0]       disp_age,
  input  logic [DISP_W*PAY_W-1:0]       disp_payload,
  input  logic [WB_W-1:0]               wb_valid,
  input  logic [WB_W*TAG_W-1:0]         wb_tag,
  input  logic [ISS_W-1:0]              iss_ready,
  output logic [ISS_W-1:0]              iss_valid,
  output logic [ISS_W*TAG_W-1:0]        iss_dest_tag,
  output logic [ISS_W*PAY_W-1:0]        iss_payload,
  output logic [$clog2(RS_DEPTH+1)-1:0] free_cnt,
  output logic                          overflow
);

  localparam int CNT_W = $clog2(RS_DEPTH + 1);
  localparam int IDX_W = $clog2(RS_DEPTH);

`ifdef RS_SPEC_WAKEUP_EN
  localparam int WK_N = WB_W + ISS_W;
`else
  localparam int WK_N = WB_W;
`endif

  // Entry state
  logic [RS_DEPTH-1:0] valid_q, valid_d;
  logic [RS_DEPTH-1:0] s1_rdy_q, s1_rdy_d;
  logic [RS_DEPTH-1:0] s2_rdy_q, s2_rdy_d;
  logic [TAG_W-1:0]    s1_tag_q [RS_DEPTH];
  logic [TAG_W-1:0]    s1_tag_d [RS_DEPTH];
  logic [TAG_W-1:0]    s2_tag_q [RS_DEPTH];
  logic [TAG_W-1:0]    s2_tag_d [RS_DEPTH];
  logic [TAG_W-1:0]    dest_q   [RS_DEPTH];
  logic [TAG_W-1:0]    dest_d   [RS_DEPTH];
  logic [AGE_W-1:0]    age_q    [RS_DEPTH];
  logic [AGE_W-1:0]    age_d    [RS_DEPTH];
  logic [PAY_W-1:0]    pay_q    [RS_DEPTH];
  logic [PAY_W-1:0]    pay_d    [RS_DEPTH];
  logic [CNT_W-1:0]    free_cnt_q, free_cnt_d;
  logic                overflow_q, overflow_d;

  logic [IDX_W-1:0]    sel_idx [ISS_W];
  logic [WK_N-1:0]     wk_valid;
  logic [TAG_W-1:0]    wk_tag [WK_N];

  assign free_cnt = free_cnt_q;
  assign overflow = overflow_q;

  // Wrap-aware: a is older than b when (a - b) mod 2^AGE_W has its MSB set.
  function automatic logic older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
    logic [AGE_W-1:0] diff;
    diff = a - b;
    return diff[AGE_W-1];
  endfunction

  // Oldest-first select. Each lane scans ascending index and only replaces its
  // candidate on a strictly older age, so equal ages stay with the lower index.
  always_comb begin
    logic [RS_DEPTH-1:0] elig;
    logic [RS_DEPTH-1:0] taken;
    logic                found;
    logic [IDX_W-1:0]    best;
    taken = '0;
    elig  = valid_q & s1_rdy_q & s2_rdy_q;
    for (int k = 0; k < ISS_W; k++) begin
      found = 1'b0;
      best  = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (elig[i] && !taken[i] && (!found || older(age_q[i], age_q[best]))) begin
          found = 1'b1;
          best  = IDX_W'(i);
        end
      end
      if (found) taken[best] = 1'b1;
      sel_idx[k]                       = best;
      iss_valid[k]                     = found & ~flush;
      iss_dest_tag[k*TAG_W +: TAG_W]   = found ? dest_q[best] : '0;
      iss_payload[k*PAY_W +: PAY_W]    = found ? pay_q[best]  : '0;
    end
  end

  // Wakeup broadcast sources
  always_comb begin
    for (int w = 0; w < WB_W; w++) begin
      wk_valid[w] = wb_valid[w];
      wk_tag[w]   = wb_tag[w*TAG_W +: TAG_W];
    end
`ifdef RS_SPEC_WAKEUP_EN
    for (int k = 0; k < ISS_W; k++) begin
      wk_valid[WB_W+k] = iss_valid[k] & iss_ready[k];
      wk_tag[WB_W+k]   = iss_dest_tag[k*TAG_W +: TAG_W];
    end
`endif
  end

  // Next-state: wakeup, issue free, allocation, flush
  always_comb begin
    logic [RS_DEPTH-1:0] avail;
    logic                placed;
    logic                h1;
    logic                h2;
    logic [CNT_W-1:0]    n_alloc;
    logic [CNT_W-1:0]    n_iss;
    valid_d    = valid_q;
    s1_rdy_d   = s1_rdy_q;
    s2_rdy_d   = s2_rdy_q;
    s1_tag_d   = s1_tag_q;
    s2_tag_d   = s2_tag_q;
    dest_d     = dest_q;
    age_d      = age_q;
    pay_d      = pay_q;
    overflow_d = overflow_q;
    n_alloc    = '0;
    n_iss      = '0;
    placed     = 1'b0;
    h1         = 1'b0;
    h2         = 1'b0;

    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int w = 0; w < WK_N; w++) begin
        if (wk_valid[w] && s1_tag_q[i] == wk_tag[w]) s1_rdy_d[i] = 1'b1;
        if (wk_valid[w] && s2_tag_q[i] == wk_tag[w]) s2_rdy_d[i] = 1'b1;
      end
    end

    for (int k = 0; k < ISS_W; k++) begin
      if (iss_valid[k] && iss_ready[k]) begin
        valid_d[sel_idx[k]] = 1'b0;
        n_iss = n_iss + CNT_W'(1);
      end
    end

    // Only entries free before this edge are allocatable; entries issued at
    // this edge become available next cycle, matching the registered free_cnt.
    avail = ~valid_q;
    for (int l = 0; l < DISP_W; l++) begin
      if (disp_valid[l] && !flush) begin
        placed = 1'b0;
        h1 = disp_src1_rdy[l];
        h2 = disp_src2_rdy[l];
        for (int w = 0; w < WK_N; w++) begin
          if (wk_valid[w] && disp_src1_tag[l*TAG_W +: TAG_W] == wk_tag[w]) h1 = 1'b1;
          if (wk_valid[w] && disp_src2_tag[l*TAG_W +: TAG_W] == wk_tag[w]) h2 = 1'b1;
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (avail[i] && !placed) begin
            placed      = 1'b1;
            avail[i]    = 1'b0;
            valid_d[i]  = 1'b1;
            s1_rdy_d[i] = h1;
            s2_rdy_d[i] = h2;
            s1_tag_d[i] = disp_src1_tag[l*TAG_W +: TAG_W];
            s2_tag_d[i] = disp_src2_tag[l*TAG_W +: TAG_W];
            dest_d[i]   = disp_dest_tag[l*TAG_W +: TAG_W];
            age_d[i]    = disp_age[l*AGE_W +: AGE_W];
            pay_d[i]    = disp_payload[l*PAY_W +: PAY_W];
            n_alloc     = n_alloc + CNT_W'(1);
          end
        end
        if (!placed) overflow_d = 1'b1;
      end
    end

    free_cnt_d = free_cnt_q - n_alloc + n_iss;

    if (flush) begin
      valid_d    = '0;
      free_cnt_d = CNT_W'(RS_DEPTH);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      s1_rdy_q   <= '0;
      s2_rdy_q   <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        s1_tag_q[i] <= '0;
        s2_tag_q[i] <= '0;
        dest_q[i]   <= '0;
        age_q[i]    <= '0;
        pay_q[i]    <= '0;
      end
      free_cnt_q <= CNT_W'(RS_DEPTH);
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      s1_rdy_q   <= s1_rdy_d;
      s2_rdy_q   <= s2_rdy_d;
      s1_tag_q   <= s1_tag_d;
      s2_tag_q   <= s2_tag_d;
      dest_q     <= dest_d;
      age_q      <= age_d;
      pay_q      <= pay_d;
      free_cnt_q <= free_cnt_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_rs_age_bank.sv
// tb/tb_rs_age_bank.sv - scoreboard bench for rs_age_bank
module tb_rs_age_bank;
  localparam int RS_DEPTH = 8;
  localparam int DISP_W = 2;
  localparam int ISS_W = 2;
  localparam int WB_W = 2;
  localparam int TAG_W = 6;
  localparam int AGE_W = 6;
  localparam int PAY_W = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush;
  logic [DISP_W-1:0]       disp_valid;
  logic [DISP_W*TAG_W-1:0] disp_src1_tag, disp_src2_tag, disp_dest_tag;
  logic [DISP_W-1:0]       disp_src1_rdy, disp_src2_rdy;
  logic [DISP_W*AGE_W-1:0] disp_age;
  logic [DISP_W*PAY_W-1:0] disp_payload;
  logic [WB_W-1:0]         wb_valid;
  logic [WB_W*TAG_W-1:0]   wb_tag;
  logic [ISS_W-1:0]        iss_ready;
  logic [ISS_W-1:0]        iss_valid;
  logic [ISS_W*TAG_W-1:0]  iss_dest_tag;
  logic [ISS_W*PAY_W-1:0]  iss_payload;
  logic [3:0]              free_cnt;
  logic                    overflow;

  rs_age_bank #(
    .RS_DEPTH(RS_DEPTH), .DISP_W(DISP_W), .ISS_W(ISS_W), .WB_W(WB_W),
    .TAG_W(TAG_W), .AGE_W(AGE_W), .PAY_W(PAY_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_dest_tag(disp_dest_tag), .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_age(disp_age), .disp_payload(disp_payload),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .iss_ready(iss_ready),
    .iss_valid(iss_valid), .iss_dest_tag(iss_dest_tag), .iss_payload(iss_payload),
    .free_cnt(free_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic [3:0]  free;
    logic [1:0]  iv;
    logic        ovf;
    bit          chk_pay;
    logic [63:0] pay0;
  } st_t;

  typedef struct {
    int          lane;
    logic [5:0]  dest;
    logic [63:0] pay;
  } iss_t;

  st_t  st_q[$];
  iss_t iss_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pay_of(input logic [5:0] d);
    return 64'hA5A5_0000_0000_0000 | {58'd0, d};
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp_v);
    end
  endfunction

  // Monitor: pops issue expectations on every accepted lane and per-cycle status expectations.
  always @(negedge clk) begin
    iss_t e;
    st_t  s;
    if (!rst) begin
      for (int k = 0; k < ISS_W; k++) begin
        if (iss_valid[k] && iss_ready[k]) begin
          if (iss_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_issue lane%0d: got dest=%0d pay=%0h, required no issue",
                     k, iss_dest_tag[k*TAG_W +: TAG_W], iss_payload[k*PAY_W +: PAY_W]);
          end else begin
            e = iss_q.pop_front();
            chk($sformatf("issue_lane%0d", k),
                {32'(k), 26'd0, iss_dest_tag[k*TAG_W +: TAG_W]}, {32'(e.lane), 26'd0, e.dest});
            chk($sformatf("issue_pay_lane%0d", k), iss_payload[k*PAY_W +: PAY_W], e.pay);
          end
        end
      end
      while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
        s = st_q.pop_front();
        chk({s.name, "_cycle"}, 64'(cyc), 64'(s.cyc));
        chk({s.name, "_free_cnt"}, 64'(free_cnt), 64'(s.free));
        chk({s.name, "_iss_valid"}, 64'(iss_valid), 64'(s.iv));
        chk({s.name, "_overflow"}, 64'(overflow), 64'(s.ovf));
        if (s.chk_pay) chk({s.name, "_lane0_pay"}, iss_payload[PAY_W-1:0], s.pay0);
      end
      if (done) begin
        chk("pending_issues", 64'(iss_q.size()), 64'd0);
        chk("pending_status", 64'(st_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  task automatic idle();
    flush = 1'b0;
    disp_valid = '0;
    disp_src1_tag = '0;
    disp_src2_tag = '0;
    disp_dest_tag = '0;
    disp_src1_rdy = '0;
    disp_src2_rdy = '0;
    disp_age = '0;
    disp_payload = '0;
    wb_valid = '0;
    wb_tag = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic disp(input int l, input logic [5:0] s1t, input logic s1r,
                      input logic [5:0] s2t, input logic s2r,
                      input logic [5:0] dst, input logic [5:0] age);
    disp_valid[l] = 1'b1;
    disp_src1_tag[l*TAG_W +: TAG_W] = s1t;
    disp_src1_rdy[l] = s1r;
    disp_src2_tag[l*TAG_W +: TAG_W] = s2t;
    disp_src2_rdy[l] = s2r;
    disp_dest_tag[l*TAG_W +: TAG_W] = dst;
    disp_age[l*AGE_W +: AGE_W] = age;
    disp_payload[l*PAY_W +: PAY_W] = pay_of(dst);
  endtask

  task automatic wb(input int l, input logic [5:0] t);
    wb_valid[l] = 1'b1;
    wb_tag[l*TAG_W +: TAG_W] = t;
  endtask

  task automatic expect_st(input string nm, input logic [3:0] fr, input logic [1:0] iv,
                           input logic ovf, input bit cp, input logic [63:0] p0);
    st_t s;
    s.cyc = cyc; s.name = nm; s.free = fr; s.iv = iv; s.ovf = ovf; s.chk_pay = cp; s.pay0 = p0;
    st_q.push_back(s);
  endtask

  task automatic exp_iss(input int lane, input logic [5:0] dst);
    iss_t e;
    e.lane = lane; e.dest = dst; e.pay = pay_of(dst);
    iss_q.push_back(e);
  endtask

  initial begin
    idle();
    iss_ready = 2'b11;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expect_st("reset", 8, 2'b00, 0, 1, 64'd0);

    // Two ready ops, ages 5 and 3
    tick(); disp(0, 0, 1, 0, 1, 1, 5); disp(1, 0, 1, 0, 1, 2, 3);
    expect_st("own_cycle", 8, 2'b00, 0, 1, 64'd0);
    tick(); expect_st("age_order", 6, 2'b11, 0, 1, pay_of(2)); exp_iss(0, 2); exp_iss(1, 1);
    // Wrap-aware ages 62 and 1
    tick(); disp(0, 0, 1, 0, 1, 3, 62); disp(1, 0, 1, 0, 1, 4, 1);
    expect_st("freed", 8, 2'b00, 0, 1, 64'd0);
    tick(); expect_st("wrap", 6, 2'b11, 0, 1, pay_of(3)); exp_iss(0, 3); exp_iss(1, 4);

    // Fill all entries waiting on tag 9
    tick(); disp(0, 9, 0, 0, 1, 10, 20); disp(1, 9, 0, 0, 1, 11, 11);
    expect_st("fill0", 8, 2'b00, 0, 1, 64'd0);
    tick(); disp(0, 9, 0, 0, 1, 12, 12); disp(1, 9, 0, 0, 1, 13, 13);
    expect_st("fill1", 6, 2'b00, 0, 1, 64'd0);
    tick(); disp(0, 9, 0, 0, 1, 14, 14); disp(1, 9, 0, 0, 1, 15, 15);
    expect_st("fill2", 4, 2'b00, 0, 1, 64'd0);
    tick(); disp(0, 9, 0, 0, 1, 16, 16); disp(1, 9, 0, 0, 1, 17, 17);
    expect_st("fill3", 2, 2'b00, 0, 1, 64'd0);
    tick(); disp(0, 0, 1, 0, 1, 30, 2);
    expect_st("full", 0, 2'b00, 0, 1, 64'd0);
    tick(); wb(1, 9);
    expect_st("overflow", 0, 2'b00, 1, 1, 64'd0);
    tick(); expect_st("wake", 0, 2'b11, 1, 1, pay_of(11)); exp_iss(0, 11); exp_iss(1, 12);

    // Hold lane 0 for 3 cycles
    for (int h = 0; h < 3; h++) begin
      tick(); iss_ready = 2'b00;
      expect_st($sformatf("hold%0d", h), 2, 2'b11, 1, 1, pay_of(13));
    end
    tick(); iss_ready = 2'b01;
    expect_st("hold_accept", 2, 2'b11, 1, 1, pay_of(13)); exp_iss(0, 13);
    tick(); iss_ready = 2'b11;
    expect_st("lane_move", 3, 2'b11, 1, 1, pay_of(14)); exp_iss(0, 14); exp_iss(1, 15);
    tick(); expect_st("drain0", 5, 2'b11, 1, 1, pay_of(16)); exp_iss(0, 16); exp_iss(1, 17);
    tick(); expect_st("drain1", 7, 2'b01, 1, 1, pay_of(10)); exp_iss(0, 10);

    // Flush with 5 valid entries plus a same-cycle dispatch
    tick(); disp(0, 20, 0, 0, 1, 40, 40); disp(1, 20, 0, 0, 1, 41, 41);
    expect_st("drained", 8, 2'b00, 1, 1, 64'd0);
    tick(); disp(0, 20, 0, 0, 1, 42, 42); disp(1, 20, 0, 0, 1, 43, 43);
    expect_st("pre_flush0", 6, 2'b00, 1, 1, 64'd0);
    tick(); disp(0, 0, 1, 0, 1, 44, 44);
    expect_st("pre_flush1", 4, 2'b00, 1, 1, 64'd0);
    tick(); flush = 1'b1; disp(0, 0, 1, 0, 1, 45, 45); disp(1, 0, 1, 0, 1, 46, 46);
    expect_st("flush_cycle", 3, 2'b00, 1, 0, 64'd0);
    tick(); expect_st("post_flush", 8, 2'b00, 1, 1, 64'd0);

    // Producer dest 12, consumer waiting on 12
    tick(); disp(0, 0, 1, 0, 1, 12, 50); disp(1, 12, 0, 0, 1, 13, 51);
    expect_st("prod_cons", 8, 2'b00, 1, 1, 64'd0);
    tick(); expect_st("producer", 6, 2'b01, 1, 1, pay_of(12)); exp_iss(0, 12);
`ifdef RS_SPEC_WAKEUP_EN
    tick(); expect_st("consumer_spec", 7, 2'b01, 1, 1, pay_of(13)); exp_iss(0, 13);
`else
    tick(); wb(0, 12);
    expect_st("consumer_wait", 7, 2'b00, 1, 1, 64'd0);
    tick(); expect_st("consumer_wb", 7, 2'b01, 1, 1, pay_of(13)); exp_iss(0, 13);
`endif

    // Dispatch-cycle bypass from both wb lanes
    tick(); disp(0, 33, 0, 34, 0, 20, 60); wb(0, 34); wb(1, 33);
    expect_st("bypass_disp", 8, 2'b00, 1, 1, 64'd0);
    tick(); expect_st("bypass", 7, 2'b01, 1, 1, pay_of(20)); exp_iss(0, 20);

    // Asynchronous reset between edges
    tick(); disp(0, 40, 0, 0, 1, 21, 1); disp(1, 40, 0, 0, 1, 22, 2);
    expect_st("pre_rst0", 8, 2'b00, 1, 1, 64'd0);
    tick(); expect_st("pre_rst1", 6, 2'b00, 1, 1, 64'd0);
    tick();
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    expect_st("async_rst", 8, 2'b00, 0, 1, 64'd0);
    tick();
    done = 1'b1;
  end
endmodule
